// File: rtl/program_counter_hs.sv
// Handshake program counter: presents the PC on a valid/ready channel and applies INC/LOAD/CALL/RET commands.
// Optional call/return stack is enabled by defining PC_RETURN_STACK_EN; default build has none.
module program_counter_hs #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 8'h56,
  parameter int               INC_W        = 2,
  parameter int               STACK_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [INC_W-1:0] cmd_inc,
  input  logic [WIDTH-1:0] cmd_addr,
  output logic [WIDTH-1:0] pc_out,
  output logic             pc_valid,
  input  logic             pc_ready,
  output logic [1:0]       stk_err
);

  typedef enum logic {PRESENT = 1'b0, WAIT_CMD = 1'b1} state_t;
  typedef enum logic [1:0] {OP_INC = 2'b00, OP_LOAD = 2'b01, OP_CALL = 2'b10, OP_RET = 2'b11} op_t;

  if (STACK_DEPTH < 2) begin : g_bad_depth
    $error("program_counter_hs: STACK_DEPTH must be at least 2");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] inc_sum;
  logic [WIDTH-1:0] target;
  logic             accept;

  assign inc_sum = pc_q + {{(WIDTH-INC_W){1'b0}}, cmd_inc};

  // Handshake FSM; the command is taken either while waiting or in the same
  // cycle the consumer takes the current PC, giving zero-bubble streaming.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
    state_d   = state_q;
    pc_d      = pc_q;
    accept    = 1'b0;
    cmd_ready = 1'b0;
    unique case (state_q)
      PRESENT: begin
        cmd_ready = pc_ready;
        if (pc_ready) begin
          if (cmd_valid) accept  = 1'b1;
          else           state_d = WAIT_CMD;
        end
      end
      WAIT_CMD: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = PRESENT;
        end
      end
      default: state_d = PRESENT;
    endcase
    if (accept) pc_d = target;
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= PRESENT;
      pc_q    <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign pc_out   = pc_q;
  assign pc_valid = (state_q == PRESENT);

`ifdef PC_RETURN_STACK_EN
  localparam int PTR_W = $clog2(STACK_DEPTH);
  localparam int CNT_W = $clog2(STACK_DEPTH + 1);

  logic [WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [PTR_W-1:0] top_q, top_d, top_inc, top_dec;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       err_q, err_d;
  logic             push, pop, empty, full;

  assign push    = accept & (op_t'(cmd_op) == OP_CALL);
  assign pop     = accept & (op_t'(cmd_op) == OP_RET);
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(STACK_DEPTH));
  assign top_inc = (top_q == PTR_W'(STACK_DEPTH - 1)) ? '0 : top_q + 1'b1;
  assign top_dec = (top_q == '0) ? PTR_W'(STACK_DEPTH - 1) : top_q - 1'b1;

  always_comb begin
    unique case (op_t'(cmd_op))
      OP_INC:  target = inc_sum;
      OP_LOAD: target = cmd_addr;
      OP_CALL: target = cmd_addr;
      OP_RET:  target = empty ? RESET_VECTOR : stack_mem[top_q];
      default: target = inc_sum;
    endcase
  end

  // Circular LIFO: when full, the slot after the top is the oldest entry, so a push overwrites it.
  always_comb begin
    top_d = top_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (push) begin
      top_d = top_inc;
      if (full) err_d[0] = 1'b1;
      else      cnt_d    = cnt_q + 1'b1;
    end else if (pop) begin
      if (empty) begin
        err_d[1] = 1'b1;
      end else begin
        top_d = top_dec;
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top_q <= '0;
      cnt_q <= '0;
      err_q <= 2'b00;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // NOTE: stack storage has no reset; the entry count guards every read, so stale contents are never used.
  always_ff @(posedge clk) begin
    if (push) stack_mem[top_inc] <= inc_sum;
  end

  assign stk_err = err_q;
`else
  always_comb begin
    unique case (op_t'(cmd_op))
      OP_INC:  target = inc_sum;
      OP_LOAD: target = cmd_addr;
      OP_CALL: target = cmd_addr;
      OP_RET:  target = inc_sum;
      default: target = inc_sum;
    endcase
  end

  assign stk_err = 2'b00;
`endif

endmodule

// File: tb/tb_program_counter_hs.sv
// Self-checking bench for program_counter_hs: directed vector table, reset/stack sequences,
// and randomized traffic against a queue-based reference model.
module tb_program_counter_hs;

  localparam logic [7:0] RV = 8'h56;
  localparam logic [1:0] INC = 2'b00, LOAD = 2'b01, CALL = 2'b10, RET = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [1:0] cmd_inc;
  logic [7:0] cmd_addr;
  logic [7:0] pc_out;
  logic       pc_valid;
  logic       pc_ready;
  logic [1:0] stk_err;

  program_counter_hs #(.WIDTH(8), .RESET_VECTOR(8'h56), .INC_W(2), .STACK_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_inc(cmd_inc), .cmd_addr(cmd_addr), .pc_out(pc_out), .pc_valid(pc_valid),
    .pc_ready(pc_ready), .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the PC, whether it is currently being presented, and the return stack as a queue.
  logic [7:0] m_pc;
  bit         m_present;
  logic [7:0] m_stack[$];
  logic [1:0] m_err;

  task automatic model_reset();
    m_pc      = RV;
    m_present = 1'b1;
    m_stack.delete();
    m_err     = 2'b00;
  endtask

  function automatic bit model_ready(input bit pr);
    return !m_present || pr;
  endfunction

  task automatic model_step(input bit v, input logic [1:0] op, input logic [1:0] inc,
                            input logic [7:0] addr, input bit pr);
    logic [7:0] ret_addr;
    ret_addr = 8'((int'(m_pc) + int'(inc)) % 256);
    if (m_present && pr && !v) begin
      m_present = 1'b0;
    end else if (model_ready(pr) && v) begin
      m_present = 1'b1;
      case (op)
        INC:  m_pc = ret_addr;
        LOAD: m_pc = addr;
`ifdef PC_RETURN_STACK_EN
        CALL: begin
          if (m_stack.size() == 4) begin
            void'(m_stack.pop_front());
            m_err[0] = 1'b1;
          end
          m_stack.push_back(ret_addr);
          m_pc = addr;
        end
        RET: begin
          if (m_stack.size() == 0) begin
            m_pc     = RV;
            m_err[1] = 1'b1;
          end else begin
            m_pc = m_stack.pop_back();
          end
        end
`else
        CALL: m_pc = addr;
        RET:  m_pc = ret_addr;
`endif
        default: m_pc = m_pc;
      endcase
    end
  endtask

  // One clock cycle: drive inputs, check cmd_ready before the edge, then check registered outputs after it.
  task automatic cycle(input bit v, input logic [1:0] op, input logic [1:0] inc,
                       input logic [7:0] addr, input bit pr, output logic rdy_o);
    cmd_valid = v;
    cmd_op    = op;
    cmd_inc   = inc;
    cmd_addr  = addr;
    pc_ready  = pr;
    #1;
    rdy_o = cmd_ready;
    check("cmd_ready", {15'd0, cmd_ready}, {15'd0, model_ready(pr)});
    @(posedge clk);
    model_step(v, op, inc, addr, pr);
    #1;
    check("pc_out", {8'd0, pc_out}, {8'd0, m_pc});
    check("pc_valid", {15'd0, pc_valid}, {15'd0, m_present});
    check("stk_err", {14'd0, stk_err}, {14'd0, m_err});
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = INC;
    cmd_inc   = 2'd0;
    cmd_addr  = 8'h00;
    pc_ready  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic       v;
    logic [1:0] op;
    logic [1:0] inc;
    logic [7:0] addr;
    logic       pr;
    logic       rdy;
    logic [7:0] pc;
    logic       pv;
  } vec_t;

  vec_t tbl[18];

  initial begin
    logic rdy;

    // Streaming increment, wrap, backpressure, bubble then load.
    tbl[0]  = '{1'b1, INC,  2'd1, 8'h00, 1'b1, 1'b1, 8'h57, 1'b1};
    tbl[1]  = '{1'b1, INC,  2'd1, 8'h00, 1'b1, 1'b1, 8'h58, 1'b1};
    tbl[2]  = '{1'b1, INC,  2'd1, 8'h00, 1'b1, 1'b1, 8'h59, 1'b1};
    tbl[3]  = '{1'b1, LOAD, 2'd0, 8'hFE, 1'b1, 1'b1, 8'hFE, 1'b1};
    tbl[4]  = '{1'b1, INC,  2'd3, 8'h00, 1'b1, 1'b1, 8'h01, 1'b1};
    tbl[5]  = '{1'b1, INC,  2'd0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b1};
    tbl[6]  = '{1'b1, INC,  2'd0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b1};
    for (int i = 7; i < 12; i++)
      tbl[i] = '{1'b1, INC, 2'd1, 8'h00, 1'b0, 1'b0, 8'h01, 1'b1};
    tbl[12] = '{1'b1, INC,  2'd1, 8'h00, 1'b1, 1'b1, 8'h02, 1'b1};
    tbl[13] = '{1'b0, INC,  2'd1, 8'h00, 1'b1, 1'b1, 8'h02, 1'b0};
    tbl[14] = '{1'b0, INC,  2'd1, 8'h00, 1'b0, 1'b1, 8'h02, 1'b0};
    tbl[15] = '{1'b0, INC,  2'd1, 8'h00, 1'b1, 1'b1, 8'h02, 1'b0};
    tbl[16] = '{1'b1, LOAD, 2'd0, 8'h80, 1'b0, 1'b1, 8'h80, 1'b1};
    tbl[17] = '{1'b1, INC,  2'd2, 8'h00, 1'b0, 1'b0, 8'h80, 1'b1};

    apply_reset();
    check("reset_pc", {8'd0, pc_out}, {8'd0, RV});
    check("reset_valid", {15'd0, pc_valid}, 16'd1);
    check("reset_ready", {15'd0, cmd_ready}, 16'd0);
    check("reset_err", {14'd0, stk_err}, 16'd0);

    for (int i = 0; i < 18; i++) begin
      cycle(tbl[i].v, tbl[i].op, tbl[i].inc, tbl[i].addr, tbl[i].pr, rdy);
      check($sformatf("tbl%0d_ready", i), {15'd0, rdy}, {15'd0, tbl[i].rdy});
      check($sformatf("tbl%0d_pc", i), {8'd0, pc_out}, {8'd0, tbl[i].pc});
      check($sformatf("tbl%0d_valid", i), {15'd0, pc_valid}, {15'd0, tbl[i].pv});
    end

    // Asynchronous reset while a bubble is being shown.
    cycle(1'b1, LOAD, 2'd0, 8'h9A, 1'b1, rdy);
    cycle(1'b0, INC, 2'd0, 8'h00, 1'b1, rdy);
    check("pre_rst_pc", {8'd0, pc_out}, 16'h009A);
    check("pre_rst_valid", {15'd0, pc_valid}, 16'd0);
    pc_ready = 1'b0;
    rst      = 1'b1;
    #1;
    check("async_rst_pc", {8'd0, pc_out}, {8'd0, RV});
    check("async_rst_valid", {15'd0, pc_valid}, 16'd1);
    check("async_rst_err", {14'd0, stk_err}, 16'd0);
    check("async_rst_ready", {15'd0, cmd_ready}, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    cycle(1'b1, LOAD, 2'd0, 8'h10, 1'b1, rdy);
`ifdef PC_RETURN_STACK_EN
    cycle(1'b1, CALL, 2'd1, 8'h40, 1'b1, rdy);
    check("call_pc", {8'd0, pc_out}, 16'h0040);
    cycle(1'b1, RET, 2'd0, 8'h00, 1'b1, rdy);
    check("ret_pc", {8'd0, pc_out}, 16'h0011);
    for (int i = 0; i < 5; i++) cycle(1'b1, CALL, 2'd1, 8'h20 + 8'(i), 1'b1, rdy);
    check("overflow_err", {14'd0, stk_err}, 16'h0001);
    for (int i = 0; i < 6; i++) cycle(1'b1, RET, 2'd0, 8'h00, 1'b1, rdy);
    check("underflow_pc", {8'd0, pc_out}, {8'd0, RV});
    check("underflow_err", {14'd0, stk_err}, 16'h0003);
`else
    cycle(1'b1, CALL, 2'd1, 8'h40, 1'b1, rdy);
    check("call_as_load", {8'd0, pc_out}, 16'h0040);
    cycle(1'b1, RET, 2'd2, 8'h00, 1'b1, rdy);
    check("ret_as_inc", {8'd0, pc_out}, 16'h0042);
    check("no_stack_err", {14'd0, stk_err}, 16'd0);
`endif

    // Randomized traffic against the model.
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0), rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
